// File: rtl/ifm_rd_resp_pkg.sv
// Definitions shared by the IFM read DMA and the per-bank read responder:
// default geometry, the returned beat layout, the read tag and the framing-FSM encoding.
package ifm_rd_resp_pkg;

    localparam int IFM_AW = 14;
    localparam int IFM_DN = 8;
    localparam int IFM_DW = 8;
    localparam int IFM_RL = 1;
    localparam int IFM_FD = 4;

    typedef struct packed {
        logic [IFM_DN*IFM_DW-1:0] data;
        logic                     first;
        logic                     last;
    } ifm_beat_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } ifm_tag_t;

    localparam logic [0:0] FRM_IDLE  = 1'b0;
    localparam logic [0:0] FRM_BURST = 1'b1;

    // A burst must open with first in IDLE and must not see a new first while open.
    function automatic logic frm_error(input logic [0:0] state, input logic first);
        return (state == FRM_IDLE) ? !first : first;
    endfunction

    function automatic logic [0:0] frm_next(input logic [0:0] state, input logic first,
                                            input logic last);
        if (first) begin
            return last ? FRM_IDLE : FRM_BURST;
        end
        if (last) begin
            return FRM_IDLE;
        end
        return state;
    endfunction

endpackage

// File: rtl/rresp_fifo.sv
// Synchronous return FIFO: DEPTH storage entries behind a registered output stage,
// with bypass into the output register when storage is empty.
module rresp_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic             load_out;
    logic             mem_rd;
    logic             bypass;
    logic             mem_wr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // The output register may take a new beat when it is empty or being popped.
    assign load_out = !out_valid || pop;
    assign mem_rd   = load_out && (mem_cnt != '0);
    assign bypass   = load_out && (mem_cnt == '0) && push;
    assign mem_wr   = push && !bypass;
    assign count    = mem_cnt + CW'(out_valid);

    // NOTE: storage is deliberately not reset; pointers and out_valid define what is live.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (mem_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (mem_wr && !mem_rd) begin
                mem_cnt <= mem_cnt + CW'(1);
            end else if (mem_rd && !mem_wr) begin
                mem_cnt <= mem_cnt - CW'(1);
            end
            if (load_out) begin
                if (mem_rd) begin
                    out_data  <= mem[rd_ptr];
                    out_valid <= 1'b1;
                end else if (bypass) begin
                    out_data  <= push_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

    no_overflow_a: assert property (@(posedge clk) disable iff (rst)
        !(mem_wr && !mem_rd && (mem_cnt == CW'(DEPTH))));

    no_underflow_a: assert property (@(posedge clk) disable iff (rst)
        !(pop && !out_valid));

endmodule

// File: rtl/ifm_rd_resp.sv
// IFM read responder for one SRAM bank: accepts tagged address beats under a credit limit,
// issues SRAM reads and returns the read data with the original first/last tags.
module ifm_rd_resp
    import ifm_rd_resp_pkg::*;
#(
    parameter int DW = IFM_DW,
    parameter int DN = IFM_DN,
    parameter int AW = IFM_AW,
    parameter int RL = IFM_RL,
    parameter int FD = IFM_FD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    addr,
    input  logic             addr_first,
    input  logic             addr_last,
    input  logic             addr_valid,
    output logic             addr_ready,
    output logic             mem_ce,
    output logic [AW-1:0]    mem_addr,
    input  logic [DN*DW-1:0] mem_rdata,
    output logic [DN*DW-1:0] data,
    output logic             data_first,
    output logic             data_last,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             err_seq
);

    localparam int CW = $clog2(FD + 1);

    typedef struct packed {
        logic [DN*DW-1:0] data;
        logic             first;
        logic             last;
    } rbeat_t;

    logic [CW-1:0]         cnt;
    logic                  accept;
    logic                  pop;
    ifm_tag_t [RL-1:0]     tag_pipe;
    rbeat_t                push_beat;
    rbeat_t                out_beat;
    logic [CW-1:0]         fifo_count;
    logic [0:0]            frm_state;
    logic [0:0]            frm_nxt;
    logic                  frm_err;

    // A credit is held from address accept until the beat leaves the output register,
    // so every issued read has a FIFO slot waiting for it.
    assign addr_ready = !rst && (cnt < CW'(FD));
    assign accept     = addr_valid && addr_ready;
    assign pop        = data_valid && data_ready;
    assign mem_ce     = accept;
    assign mem_addr   = accept ? addr : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (accept && !pop) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !accept) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Tags travel alongside the SRAM read; the last stage lines up with mem_rdata.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe[0] <= '{valid: accept, first: addr_first, last: addr_last};
            for (int i = 1; i < RL; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign push_beat = '{data: mem_rdata, first: tag_pipe[RL-1].first,
                         last: tag_pipe[RL-1].last};

    rresp_fifo #(
        .WIDTH ($bits(rbeat_t)),
        .DEPTH (FD)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tag_pipe[RL-1].valid),
        .push_data (push_beat),
        .pop       (pop),
        .out_data  (out_beat),
        .out_valid (data_valid),
        .count     (fifo_count)
    );

    assign data       = out_beat.data;
    assign data_first = out_beat.first;
    assign data_last  = out_beat.last;

    always_comb begin
        // NOTE: defaults come first so no path leaves an output unassigned (no latch).
        frm_nxt = frm_state;
        frm_err = 1'b0;
        if (accept) begin
            frm_nxt = frm_next(frm_state, addr_first, addr_last);
            frm_err = frm_error(frm_state, addr_first);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frm_state <= FRM_IDLE;
            err_seq   <= 1'b0;
        end else begin
            frm_state <= frm_nxt;
            if (frm_err) begin
                err_seq <= 1'b1;
            end
        end
    end

    credit_bound_a: assert property (@(posedge clk) disable iff (rst)
        cnt <= CW'(FD));

    fifo_within_credit_a: assert property (@(posedge clk) disable iff (rst)
        fifo_count <= cnt);

endmodule

// File: tb/tb_ifm_rd_resp.sv
// Scoreboard bench for ifm_rd_resp: directed address beats feed an expectation queue,
// an SRAM model answers reads, and a negedge monitor checks every returned beat.
module tb_ifm_rd_resp;

    localparam int AW  = 14;
    localparam int DBW = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  addr;
    logic           addr_first;
    logic           addr_last;
    logic           addr_valid;
    logic           addr_ready;
    logic           mem_ce;
    logic [AW-1:0]  mem_addr;
    logic [DBW-1:0] mem_rdata;
    logic [DBW-1:0] data;
    logic           data_first;
    logic           data_last;
    logic           data_valid;
    logic           data_ready;
    logic           err_seq;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int waits = 0;
    int pop_count = 0;
    int first_pop_cyc = 0;
    int last_pop_cyc  = 0;
    int last_acc_cyc  = 0;

    logic [65:0] exp_q[$];
    logic [65:0] mon_cur;
    logic [65:0] prev_beat;
    bit          prev_stall = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifm_rd_resp #(
        .DW (8),
        .DN (8),
        .AW (AW),
        .RL (1),
        .FD (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .addr_first (addr_first),
        .addr_last  (addr_last),
        .addr_valid (addr_valid),
        .addr_ready (addr_ready),
        .mem_ce     (mem_ce),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .data       (data),
        .data_first (data_first),
        .data_last  (data_last),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .err_seq    (err_seq)
    );

    function automatic logic [DBW-1:0] mem_word(input logic [AW-1:0] a);
        return {2'b01, a, 2'b10, ~a, 32'hD000_0000 ^ {18'h0, a}};
    endfunction

    // SRAM with one cycle read latency; idle cycles return noise.
    always @(posedge clk) begin
        if (mem_ce) mem_rdata <= mem_word(mem_addr);
        else        mem_rdata <= {$urandom, $urandom};
    end

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        mon_cur = {data, data_first, data_last};
        if (prev_stall && data_valid === 1'b1) check("hold", mon_cur, prev_beat);
        if (data_valid === 1'b1 && data_ready) begin
            check("sb_has_expect", 66'(exp_q.size() != 0), 66'd1);
            if (exp_q.size() != 0) check("beat", mon_cur, exp_q.pop_front());
            if (pop_count == 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            pop_count++;
        end
        prev_stall = (data_valid === 1'b1) && !data_ready;
        prev_beat  = mon_cur;
    end

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [AW-1:0] a, input logic f, input logic l);
        int  n   = 0;
        bit  got = 1'b0;
        addr = a; addr_first = f; addr_last = l; addr_valid = 1'b1;
        while (!got && n < 200) begin
            @(negedge clk);
            if (addr_ready) got = 1'b1;
            else n++;
        end
        check("accept", 66'(got), 66'd1);
        if (got) begin
            check("mem_ce", 66'(mem_ce), 66'd1);
            check("mem_addr", 66'(mem_addr), 66'(a));
            exp_q.push_back({mem_word(a), f, l});
            last_acc_cyc = cyc;
            @(posedge clk); #1;
        end
        addr_valid = 1'b0;
        waits += n;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 66'(exp_q.size()), 66'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr_ready"}, 66'(addr_ready), 66'd0);
        check({tag, "_data_valid"}, 66'(data_valid), 66'd0);
        check({tag, "_mem_ce"},     66'(mem_ce),     66'd0);
        check({tag, "_mem_addr"},   66'(mem_addr),   66'd0);
        check({tag, "_err_seq"},    66'(err_seq),    66'd0);
        check({tag, "_data_bus"},   {data, data_first, data_last}, 66'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench stalled at cycle %0d", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; addr = '0; addr_first = 1'b0; addr_last = 1'b0;
        addr_valid = 1'b0; data_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_state("rst0");
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 66'(addr_ready), 66'd1);
        @(posedge clk); #1;

        // Single beat: data two cycles after the read enable.
        send(14'h0010, 1'b1, 1'b1);
        drain("drain_single");
        check("single_latency", 66'(last_pop_cyc - last_acc_cyc), 66'd2);

        // 16-beat burst streams at one beat per cycle in both directions.
        waits = 0; pop_count = 0;
        for (int i = 0; i < 16; i++) send(AW'(i), i == 0, i == 15);
        drain("drain_burst");
        check("burst_no_stall", 66'(waits), 66'd0);
        check("burst_count", 66'(pop_count), 66'd16);
        check("burst_back_to_back", 66'(last_pop_cyc - first_pop_cyc), 66'd15);

        // Consumer stalled: four credits, then blocked until pops free them.
        waits = 0; pop_count = 0; data_ready = 1'b0;
        send(14'h0100, 1'b1, 1'b0);
        send(14'h0101, 1'b0, 1'b0);
        send(14'h0102, 1'b0, 1'b0);
        send(14'h0103, 1'b0, 1'b1);
        check("fill_no_stall", 66'(waits), 66'd0);
        repeat (3) @(negedge clk);
        check("full_ready_low", 66'(addr_ready), 66'd0);
        check("full_data_valid", 66'(data_valid), 66'd1);
        @(posedge clk); #1;
        fork
            begin
                send(14'h0104, 1'b1, 1'b0);
                send(14'h0105, 1'b0, 1'b1);
            end
            begin
                repeat (4) @(posedge clk);
                #1 data_ready = 1'b1;
            end
        join
        check("blocked_waits", 66'(waits), 66'd5);
        drain("drain_full");
        check("full_count", 66'(pop_count), 66'd6);

        // Accept and pop on the same edge at cnt = FD-1.
        data_ready = 1'b0;
        send(14'h0200, 1'b1, 1'b1);
        send(14'h0201, 1'b1, 1'b1);
        send(14'h0202, 1'b1, 1'b1);
        repeat (2) @(posedge clk); #1;
        data_ready = 1'b1;
        send(14'h0203, 1'b1, 1'b1);
        data_ready = 1'b0;
        @(negedge clk);
        check("ready_after_acc_pop", 66'(addr_ready), 66'd1);
        @(posedge clk); #1;
        send(14'h0204, 1'b1, 1'b1);
        @(negedge clk);
        check("ready_at_full", 66'(addr_ready), 66'd0);
        @(posedge clk); #1;
        data_ready = 1'b1;
        drain("drain_acc_pop");
        check("err_clean", 66'(err_seq), 66'd0);

        // Framing: a new first inside an open burst is flagged and stays flagged.
        send(14'h0300, 1'b1, 1'b0);
        send(14'h0301, 1'b0, 1'b0);
        check("err_before", 66'(err_seq), 66'd0);
        send(14'h0302, 1'b1, 1'b0);
        check("err_set", 66'(err_seq), 66'd1);
        send(14'h0303, 1'b0, 1'b1);
        send(14'h0304, 1'b1, 1'b1);
        check("err_sticky", 66'(err_seq), 66'd1);
        drain("drain_framing");

        // Reset with reads outstanding: nothing may come out afterwards.
        data_ready = 1'b0;
        send(14'h0400, 1'b1, 1'b1);
        send(14'h0401, 1'b1, 1'b1);
        send(14'h0402, 1'b1, 1'b1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        check_reset_state("rst1");
        @(posedge clk); #1;
        rst = 1'b0; data_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_beat_after_rst", 66'(data_valid), 66'd0);
        end
        @(posedge clk); #1;
        send(14'h0405, 1'b1, 1'b1);
        drain("drain_post_rst");
        check("err_cleared", 66'(err_seq), 66'd0);
        send(14'h0406, 1'b0, 1'b1);
        check("err_nofirst_idle", 66'(err_seq), 66'd1);
        drain("drain_last");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
